// File: rtl/lfsr_rand_gen_if.sv
// Random-value delivery channel: valid/ready handshake plus FIFO occupancy.
// The producer drives valid/data/count; the consumer drives ready.
interface lfsr_rand_gen_if #(
    parameter int BITS = 4,
    parameter int CW   = 3
);
    logic            rand_valid;
    logic            rand_ready;
    logic [BITS-1:0] rand_data;
    logic [CW-1:0]   rand_count;

    modport master (output rand_valid, output rand_data, output rand_count, input rand_ready);
    modport slave  (input rand_valid, input rand_data, input rand_count, output rand_ready);
endinterface

// File: rtl/lfsr_rand_gen.sv
// Fibonacci-LFSR random source (BITS steps/cycle) feeding a DEPTH-entry FIFO; optional
// rejection sampling to [0, RANGE) when LFSR_RAND_REJECT_EN is defined. Push latency 1 edge;
// candidates are dropped when the FIFO is full and no pop happens in the same cycle.
module lfsr_rand_gen #(
    parameter int             N          = 16,
    parameter logic [N-1:0]   POLYNOMIAL = 16'hD008,
    parameter int             BITS       = 4,
    parameter logic [BITS:0]  RANGE      = 10,
    parameter int             DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    seed_load_i,
    input  logic [N-1:0]            seed_i,
    output logic [N-1:0]            lfsr_state_o,
    lfsr_rand_gen_if.master         rnd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (N < 3 || BITS < 1 || BITS > N) begin : g_bad_width
        $error("lfsr_rand_gen: need N >= 3 and 1 <= BITS <= N");
    end
    if (RANGE == 0 || int'(RANGE) > (1 << BITS)) begin : g_bad_range
        $error("lfsr_rand_gen: RANGE must lie in [1, 2**BITS]");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
        $error("lfsr_rand_gen: DEPTH must be a power of two >= 2");
    end

    logic [N-1:0]    state_q, state_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] cand;
    logic            cand_ok;
    logic            pop;
    logic            push;

    // BITS single steps unrolled; all-ones is the absorbing state under XNOR feedback.
    always_comb begin
        state_d = state_q;
        for (int i = 0; i < BITS; i++) begin
            state_d = {state_d[N-2:0], ~^(POLYNOMIAL & state_d)};
        end
    end

    assign cand = state_d[N-1 -: BITS];

`ifdef LFSR_RAND_REJECT_EN
    assign cand_ok = ({1'b0, cand} < RANGE);
`else
    assign cand_ok = 1'b1;
`endif

    assign pop  = (cnt_q != '0) && rnd.rand_ready;
    assign push = cand_ok && ((cnt_q < CW'(DEPTH)) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (seed_load_i) begin
            state_q <= (&seed_i) ? '0 : seed_i;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                mem_q[wr_q] <= cand;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign rnd.rand_valid = (cnt_q != '0);
    assign rnd.rand_data  = mem_q[rd_q];
    assign rnd.rand_count = cnt_q;
    assign lfsr_state_o   = state_q;
endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen with N=4, POLYNOMIAL=4'h9, BITS=2, DEPTH=4.
// Builds with or without LFSR_RAND_REJECT_EN; expected values are hand-derived.
module tb_lfsr_rand_gen;
    localparam int N     = 4;
    localparam int BITS  = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef LFSR_RAND_REJECT_EN
    localparam logic [BITS:0] RNG = 3'd2;
`else
    localparam logic [BITS:0] RNG = 3'd4;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         seed_load = 1'b0;
    logic [N-1:0] seed = '0;
    logic [N-1:0] lfsr_state;
    int           tests = 0;
    int           fails = 0;

    lfsr_rand_gen_if #(.BITS(BITS), .CW(CW)) rif ();

    lfsr_rand_gen #(
        .N(N), .POLYNOMIAL(4'h9), .BITS(BITS), .RANGE(RNG), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seed_load_i(seed_load), .seed_i(seed),
        .lfsr_state_o(lfsr_state), .rnd(rif.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rif.rand_ready = 1'b1;
        #12;
        tests++;
        if ({lfsr_state, rif.rand_valid, rif.rand_data, rif.rand_count} !== '0) begin
            fails++;
            $display("FAIL reset_state: state=%b valid=%b data=%0d count=%0d, want all zero",
                     lfsr_state, rif.rand_valid, rif.rand_data, rif.rand_count);
        end
        rst_n = 1'b1;
    endtask

`ifndef LFSR_RAND_REJECT_EN
    task automatic test_sequence();
        logic [3:0] exp_s [6] = '{4'b0010, 4'b1010, 4'b1001, 4'b0110, 4'b1011, 4'b1110};
        logic [1:0] exp_d [6] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (lfsr_state !== exp_s[i]) begin
                fails++;
                $display("FAIL seq_state[%0d]: got %b want %b", i, lfsr_state, exp_s[i]);
            end
            tests++;
            if (rif.rand_valid !== 1'b1 || rif.rand_data !== exp_d[i] || rif.rand_count !== 3'd1) begin
                fails++;
                $display("FAIL seq_data[%0d]: valid=%b data=%0d count=%0d want 1/%0d/1",
                         i, rif.rand_valid, rif.rand_data, rif.rand_count, exp_d[i]);
            end
        end
    endtask

    task automatic test_stall_full();
        logic [1:0] exp_h [6] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0};
        step();
        do_reset();
        rif.rand_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            tests++;
            if (rif.rand_data !== 2'd0 || rif.rand_count !== CW'(i < 4 ? i + 1 : 4)) begin
                fails++;
                $display("FAIL stall[%0d]: data=%0d count=%0d want 0/%0d",
                         i, rif.rand_data, rif.rand_count, (i < 4 ? i + 1 : 4));
            end
        end
        rif.rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (rif.rand_count !== 3'd4 || rif.rand_data !== exp_h[i]) begin
                fails++;
                $display("FAIL full_pop[%0d]: count=%0d head=%0d want 4/%0d",
                         i, rif.rand_count, rif.rand_data, exp_h[i]);
            end
        end
    endtask
`else
    task automatic test_reject();
        logic       exp_v [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] exp_d [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (rif.rand_valid !== exp_v[i] || (exp_v[i] && rif.rand_data !== exp_d[i])) begin
                fails++;
                $display("FAIL reject[%0d]: valid=%b data=%0d want %b/%0d",
                         i, rif.rand_valid, rif.rand_data, exp_v[i], exp_d[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            tests++;
            if (rif.rand_valid === 1'b1 && rif.rand_data >= 2'd2) begin
                fails++;
                $display("FAIL reject_bound[%0d]: data=%0d want < 2", i, rif.rand_data);
            end
        end
    endtask
`endif

    task automatic test_seed();
        rif.rand_ready = 1'b0;
        seed_load = 1'b1;
        seed = 4'b1111;
        step();
        tests++;
        if (lfsr_state !== 4'b0000 || rif.rand_valid !== 1'b0 || rif.rand_count !== 3'd0) begin
            fails++;
            $display("FAIL seed_lockup: state=%b valid=%b count=%0d want 0000/0/0",
                     lfsr_state, rif.rand_valid, rif.rand_count);
        end
        seed_load = 1'b0;
        step();
        tests++;
        if (lfsr_state !== 4'b0010 || rif.rand_valid !== 1'b1 || rif.rand_data !== 2'd0
            || rif.rand_count !== 3'd1) begin
            fails++;
            $display("FAIL seed_next: state=%b valid=%b data=%0d count=%0d want 0010/1/0/1",
                     lfsr_state, rif.rand_valid, rif.rand_data, rif.rand_count);
        end
        seed_load = 1'b1;
        seed = 4'b0110;
        rif.rand_ready = 1'b1;
        step();
        tests++;
        if (lfsr_state !== 4'b0110 || rif.rand_valid !== 1'b0 || rif.rand_count !== 3'd0) begin
            fails++;
            $display("FAIL seed_load: state=%b valid=%b count=%0d want 0110/0/0",
                     lfsr_state, rif.rand_valid, rif.rand_count);
        end
        seed_load = 1'b0;
        step();
        tests++;
        if (lfsr_state !== 4'b1011) begin
            fails++;
            $display("FAIL seed_step: state=%b want 1011", lfsr_state);
        end
`ifndef LFSR_RAND_REJECT_EN
        tests++;
        if (rif.rand_valid !== 1'b1 || rif.rand_data !== 2'd2) begin
            fails++;
            $display("FAIL seed_push: valid=%b data=%0d want 1/2", rif.rand_valid, rif.rand_data);
        end
`endif
    endtask

    task automatic test_async_reset();
        rif.rand_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        tests++;
        if (rif.rand_count !== 3'd4) begin
            fails++;
            $display("FAIL prefill: count=%0d want 4", rif.rand_count);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({lfsr_state, rif.rand_valid, rif.rand_data, rif.rand_count} !== '0) begin
            fails++;
            $display("FAIL async_reset: state=%b valid=%b data=%0d count=%0d, want all zero",
                     lfsr_state, rif.rand_valid, rif.rand_data, rif.rand_count);
        end
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rif.rand_ready = 1'b0;
        test_reset();
`ifndef LFSR_RAND_REJECT_EN
        test_sequence();
        test_stall_full();
`else
        test_reject();
`endif
        test_seed();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
